// File: rtl/spi_sensor_pkg.sv
// Shared constants and types for the SPI sensor responder: register map,
// CTRL reset value, FSM state encoding and the sample payload.
package spi_sensor_pkg;

  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned SAMPLE_W = 16;

  localparam logic [ADDR_W-1:0] ADDR_WHO_AM_I = 6'h0F;
  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 6'h20;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 6'h27;
  localparam logic [ADDR_W-1:0] ADDR_OUT_X_L  = 6'h28;
  localparam logic [ADDR_W-1:0] ADDR_OUT_X_H  = 6'h29;
  localparam logic [ADDR_W-1:0] ADDR_OUT_Y_L  = 6'h2A;
  localparam logic [ADDR_W-1:0] ADDR_OUT_Y_H  = 6'h2B;
  localparam logic [ADDR_W-1:0] ADDR_OUT_Z_L  = 6'h2C;
  localparam logic [ADDR_W-1:0] ADDR_OUT_Z_H  = 6'h2D;

  localparam logic [BYTE_W-1:0] CTRL_RESET = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DUMMY,
    ST_RD_DATA,
    ST_WR_DATA
  } state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] z;
    logic [SAMPLE_W-1:0] y;
    logic [SAMPLE_W-1:0] x;
  } sample_t;

endpackage

// File: rtl/spi_sensor_responder_if.sv
// SPI wire bundle between a bus master and the sensor responder.
interface spi_sensor_responder_if;
  logic SCLK;
  logic SS;
  logic MOSI;
  logic MISO;

  modport master (output SCLK, output SS, output MOSI, input MISO);
  modport slave  (input SCLK, input SS, input MOSI, output MISO);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with rise/fall strobes
// derived from the synchronized level.
module spi_sync_edge #(
  parameter int unsigned STAGES   = 2,
  parameter logic        IDLE_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= {STAGES{IDLE_VAL}};
      prev_q  <= IDLE_VAL;
    end else begin
      chain_q <= STAGES'({chain_q, din});
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign sync   = chain_q[STAGES-1];
  assign rise_c = sync & ~prev_q;
  assign fall_c = ~sync & prev_q;

endmodule

// File: rtl/spi_sensor_responder.sv
// Mode-3 SPI register responder for a 3-axis sensor: WHO_AM_I, CTRL, STATUS
// and tear-free little-endian sample readout with optional auto-increment.
module spi_sensor_responder
  import spi_sensor_pkg::*;
#(
  parameter logic [7:0]  WHO_AM_I    = 8'hD4,
  parameter int unsigned DUMMY_BYTES = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_sensor_responder_if.slave spi,
  input  logic signed [15:0]   data_x,
  input  logic signed [15:0]   data_y,
  input  logic signed [15:0]   data_z,
  input  logic                 data_valid,
  output logic [7:0]           ctrl_reg,
  output logic                 busy
);

  localparam int unsigned DUMMY_W  = $clog2(DUMMY_BYTES + 2);
  localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 2);
  localparam logic [DUMMY_W-1:0]  DUMMY_LAST  = DUMMY_W'(DUMMY_BYTES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SYNC_STAGES + 1);

  logic sclk_s, sclk_rise_c, sclk_fall_c;
  logic ss_s, ss_rise_c, ss_fall_c;
  logic mosi_s, mosi_rise_c, mosi_fall_c;
  logic unused_mosi_edges_c;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .reset(reset), .din(spi.SCLK),
    .sync(sclk_s), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_ss_sync (
    .clk(clk), .reset(reset), .din(spi.SS),
    .sync(ss_s), .rise_c(ss_rise_c), .fall_c(ss_fall_c)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .reset(reset), .din(spi.MOSI),
    .sync(mosi_s), .rise_c(mosi_rise_c), .fall_c(mosi_fall_c)
  );
  assign unused_mosi_edges_c = mosi_rise_c ^ mosi_fall_c;

  state_t              state_q, state_d;
  logic [2:0]          bit_cnt_q;
  logic [7:0]          shreg_q;
  logic                ms_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DUMMY_W-1:0]  dummy_cnt_q;
  logic [SETTLE_W-1:0] settle_cnt_q;
  logic                armed_q;
  sample_t             shadow_q, snap_q, pend_q;
  logic                pend_valid_q;
  logic                status_q;
  logic                rd_last_q;
  logic                miso_q;

  logic                byte_done_c, start_c, end_txn_c;
  logic [7:0]          cmd_c, rd_byte_c;
  sample_t             new_sample_c;

  assign byte_done_c  = sclk_rise_c && (bit_cnt_q == 3'd7);
  assign cmd_c        = {shreg_q[6:0], mosi_s};
  assign start_c      = (state_q == ST_IDLE) && ss_fall_c && armed_q;
  assign end_txn_c    = ss_rise_c && (state_q != ST_IDLE);
  assign new_sample_c = sample_t'({data_z, data_y, data_x});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and the read-data mux for the current address
  always_comb begin
    state_d   = state_q;
    rd_byte_c = 8'h00;
    case (addr_q)
      ADDR_WHO_AM_I: rd_byte_c = WHO_AM_I;
      ADDR_CTRL:     rd_byte_c = ctrl_reg;
      ADDR_STATUS:   rd_byte_c = {7'b0, status_q};
      ADDR_OUT_X_L:  rd_byte_c = snap_q.x[7:0];
      ADDR_OUT_X_H:  rd_byte_c = snap_q.x[15:8];
      ADDR_OUT_Y_L:  rd_byte_c = snap_q.y[7:0];
      ADDR_OUT_Y_H:  rd_byte_c = snap_q.y[15:8];
      ADDR_OUT_Z_L:  rd_byte_c = snap_q.z[7:0];
      ADDR_OUT_Z_H:  rd_byte_c = snap_q.z[15:8];
      default:       rd_byte_c = 8'h00;
    endcase
    case (state_q)
      ST_IDLE:  if (start_c) state_d = ST_CMD;
      ST_CMD: begin
        if (byte_done_c) begin
          if (!cmd_c[7])             state_d = ST_WR_DATA;
          else if (DUMMY_BYTES != 0) state_d = ST_DUMMY;
          else                       state_d = ST_RD_DATA;
        end
      end
      ST_DUMMY: if (byte_done_c && dummy_cnt_q == DUMMY_LAST) state_d = ST_RD_DATA;
      default:  state_d = state_q;
    endcase
    if (end_txn_c) state_d = ST_IDLE;
  end

  // Shift/address datapath, MISO driver and CTRL register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 8'h00;
      ms_q         <= 1'b0;
      addr_q       <= '0;
      dummy_cnt_q  <= '0;
      miso_q       <= 1'b0;
      busy         <= 1'b0;
      ctrl_reg     <= CTRL_RESET;
      settle_cnt_q <= '0;
      armed_q      <= 1'b0;
    end else begin
      busy <= (state_d != ST_IDLE);
      if (settle_cnt_q != SETTLE_LAST) settle_cnt_q <= settle_cnt_q + SETTLE_W'(1);
      else if (ss_s && sclk_s)         armed_q <= 1'b1;

      if (state_q == ST_IDLE) bit_cnt_q <= 3'd0;
      else if (sclk_rise_c)   bit_cnt_q <= bit_cnt_q + 3'd1;
      if (sclk_rise_c) shreg_q <= cmd_c;

      if (byte_done_c) begin
        case (state_q)
          ST_CMD: begin
            ms_q        <= cmd_c[6];
            addr_q      <= cmd_c[5:0];
            dummy_cnt_q <= '0;
          end
          ST_DUMMY:   dummy_cnt_q <= dummy_cnt_q + DUMMY_W'(1);
          ST_RD_DATA: if (ms_q) addr_q <= addr_q + 6'd1;
          ST_WR_DATA: begin
            if (addr_q == ADDR_CTRL) ctrl_reg <= cmd_c;
            if (ms_q) addr_q <= addr_q + 6'd1;
          end
          default: ;
        endcase
      end

      // MISO is bit-serial MSB first, advanced on each synchronized SCLK fall
      if (state_q == ST_IDLE || end_txn_c) begin
        miso_q <= 1'b0;
      end else if (sclk_fall_c) begin
        case (state_q)
          ST_DUMMY:   miso_q <= 1'b1;
          ST_RD_DATA: miso_q <= rd_byte_c[~bit_cnt_q];
          default:    miso_q <= 1'b0;
        endcase
      end
    end
  end

  // Sample shadow, in-flight snapshot, pending sample and STATUS.new_data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q     <= '0;
      snap_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      status_q     <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      if (start_c) begin
        snap_q    <= shadow_q;
        rd_last_q <= 1'b0;
      end else if (byte_done_c && state_q == ST_RD_DATA && addr_q == ADDR_OUT_Z_H) begin
        rd_last_q <= 1'b1;
      end

      if (end_txn_c) begin
        pend_valid_q <= 1'b0;
        if (data_valid) begin
          shadow_q <= new_sample_c;
          status_q <= 1'b1;
        end else if (pend_valid_q) begin
          shadow_q <= pend_q;
          status_q <= 1'b1;
        end else if (rd_last_q) begin
          status_q <= 1'b0;
        end
      end else if (data_valid) begin
        if (busy) begin
          pend_q       <= new_sample_c;
          pend_valid_q <= 1'b1;
        end else begin
          shadow_q <= new_sample_c;
          status_q <= 1'b1;
        end
      end
    end
  end

  assign spi.MISO = miso_q;

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Directed bench: mode-3 SPI master driving two responders (no dummy / one
// dummy byte) with hand-computed expected register and sample bytes.
module tb_spi_sensor_responder;

  logic clk = 1'b0;
  logic reset;
  logic sclk, mosi, ss0, ss1;
  logic signed [15:0] dx, dy, dz;
  logic dv;
  logic [7:0] ctrl0, ctrl1;
  logic busy0, busy1;
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  spi_sensor_responder_if spi0 ();
  spi_sensor_responder_if spi1 ();
  assign spi0.SCLK = sclk;
  assign spi0.SS   = ss0;
  assign spi0.MOSI = mosi;
  assign spi1.SCLK = sclk;
  assign spi1.SS   = ss1;
  assign spi1.MOSI = mosi;

  spi_sensor_responder #(.WHO_AM_I(8'hD4), .DUMMY_BYTES(0), .SYNC_STAGES(2)) u_dut0 (
    .clk(clk), .reset(reset), .spi(spi0),
    .data_x(dx), .data_y(dy), .data_z(dz), .data_valid(dv),
    .ctrl_reg(ctrl0), .busy(busy0)
  );
  spi_sensor_responder #(.WHO_AM_I(8'hD4), .DUMMY_BYTES(1), .SYNC_STAGES(2)) u_dut1 (
    .clk(clk), .reset(reset), .spi(spi1),
    .data_x(dx), .data_y(dy), .data_z(dz), .data_valid(dv),
    .ctrl_reg(ctrl1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic spi_bits(input int sel, input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      sclk = 1'b0;
      mosi = tx[i];
      #40;
      rx[i] = (sel == 0) ? spi0.MISO : spi1.MISO;
      sclk = 1'b1;
      #40;
    end
  endtask

  task automatic spi_begin(input int sel);
    if (sel == 0) ss0 = 1'b0;
    else          ss1 = 1'b0;
    #80;
  endtask

  task automatic spi_end();
    ss0 = 1'b1;
    ss1 = 1'b1;
    #100;
  endtask

  task automatic read1(input int sel, input logic [7:0] cmd, output logic [7:0] rx);
    logic [7:0] junk;
    spi_begin(sel);
    spi_bits(sel, cmd, 8, junk);
    spi_bits(sel, 8'h00, 8, rx);
    spi_end();
  endtask

  task automatic pulse_dv(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    dx = x; dy = y; dz = z;
    dv = 1'b1;
    #10;
    dv = 1'b0;
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] exp_burst [6];
    sclk = 1'b1; mosi = 1'b0; ss0 = 1'b1; ss1 = 1'b1;
    dx = '0; dy = '0; dz = '0; dv = 1'b0;
    reset = 1'b1;
    #2;
    #30;
    check("reset_miso", 16'(spi0.MISO), 16'h0);
    check("reset_busy", 16'(busy0), 16'h0);
    check("reset_ctrl", 16'(ctrl0), 16'h07);
    reset = 1'b0;
    #100;

    // WHO_AM_I single read, busy visible mid-transaction
    spi_begin(0);
    spi_bits(0, 8'h8F, 8, rx);
    check("busy_mid_txn", 16'(busy0), 16'h1);
    spi_bits(0, 8'h00, 8, rx);
    spi_end();
    check("who_am_i", 16'(rx), 16'hD4);
    check("busy_after_txn", 16'(busy0), 16'h0);

    read1(0, 8'hA7, rx);
    check("status_initial", 16'(rx), 16'h00);
    read1(0, 8'hA0, rx);
    check("ctrl_read_reset", 16'(rx), 16'h07);

    // New sample while idle, then a six-byte auto-increment burst
    pulse_dv(16'h7FFF, 16'h8001, 16'h0100);
    #20;
    read1(0, 8'hA7, rx);
    check("status_new_data", 16'(rx), 16'h01);
    exp_burst = '{8'hFF, 8'h7F, 8'h01, 8'h80, 8'h00, 8'h01};
    spi_begin(0);
    spi_bits(0, 8'hE8, 8, rx);
    for (int b = 0; b < 6; b++) begin
      spi_bits(0, 8'h00, 8, rx);
      check($sformatf("burst1_byte%0d", b), 16'(rx), 16'(exp_burst[b]));
    end
    spi_end();
    read1(0, 8'hA7, rx);
    check("status_cleared", 16'(rx), 16'h00);

    // CTRL write, then a truncated write that must be discarded
    spi_begin(0);
    spi_bits(0, 8'h20, 8, rx);
    spi_bits(0, 8'h5A, 8, rx);
    spi_end();
    check("ctrl_write", 16'(ctrl0), 16'h5A);
    spi_begin(0);
    spi_bits(0, 8'h20, 8, rx);
    spi_bits(0, 8'h00, 5, rx);
    spi_end();
    check("ctrl_partial_write", 16'(ctrl0), 16'h5A);
    read1(0, 8'hA0, rx);
    check("ctrl_readback", 16'(rx), 16'h5A);

    // Sample arriving mid-burst: old snapshot now, new one next burst
    spi_begin(0);
    spi_bits(0, 8'hE8, 8, rx);
    spi_bits(0, 8'h00, 8, rx);
    spi_bits(0, 8'h00, 8, rx);
    pulse_dv(16'h1234, 16'hABCD, 16'hFEDC);
    for (int b = 2; b < 6; b++) begin
      spi_bits(0, 8'h00, 8, rx);
      check($sformatf("burst2_byte%0d", b), 16'(rx), 16'(exp_burst[b]));
    end
    spi_end();
    read1(0, 8'hA7, rx);
    check("status_pending_applied", 16'(rx), 16'h01);
    exp_burst = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'hDC, 8'hFE};
    spi_begin(0);
    spi_bits(0, 8'hE8, 8, rx);
    for (int b = 0; b < 6; b++) begin
      spi_bits(0, 8'h00, 8, rx);
      check($sformatf("burst3_byte%0d", b), 16'(rx), 16'(exp_burst[b]));
    end
    spi_end();
    read1(0, 8'hA7, rx);
    check("status_cleared2", 16'(rx), 16'h00);

    // MS = 0 holds the address across bytes
    spi_begin(0);
    spi_bits(0, 8'hA8, 8, rx);
    spi_bits(0, 8'h00, 8, rx);
    check("hold_byte0", 16'(rx), 16'h34);
    spi_bits(0, 8'h00, 8, rx);
    check("hold_byte1", 16'(rx), 16'h34);
    spi_end();

    // One-dummy-byte instance: FF turnaround, then OUT_X_L
    spi_begin(1);
    spi_bits(1, 8'hA8, 8, rx);
    spi_bits(1, 8'h00, 8, rx);
    check("dummy_byte", 16'(rx), 16'hFF);
    spi_bits(1, 8'h00, 8, rx);
    check("dummy_out_x_l", 16'(rx), 16'h34);
    spi_end();
    check("dummy_busy_after", 16'(busy1), 16'h0);
    check("dummy_ctrl", 16'(ctrl1), 16'h07);

    // Reset pulse during the fourth data bit of a read
    spi_begin(0);
    spi_bits(0, 8'h8F, 8, rx);
    spi_bits(0, 8'h00, 3, rx);
    sclk = 1'b0;
    #20;
    reset = 1'b1;
    #20;
    check("midreset_miso", 16'(spi0.MISO), 16'h0);
    check("midreset_busy", 16'(busy0), 16'h0);
    check("midreset_ctrl", 16'(ctrl0), 16'h07);
    sclk = 1'b1;
    ss0 = 1'b1;
    #20;
    reset = 1'b0;
    #100;
    check("postreset_busy", 16'(busy0), 16'h0);
    read1(0, 8'h8F, rx);
    check("postreset_who_am_i", 16'(rx), 16'hD4);
    read1(0, 8'hA0, rx);
    check("postreset_ctrl_read", 16'(rx), 16'h07);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
